// File: rtl/lvds_rx_frame_writer.sv
// Packs LVDS bytes into 32-bit words and writes them into a ping-pong pair of SRAM banks.
// The write is one cycle after the 4th byte and BANK_RDY two cycles after it; bytes are dropped (OVERFLOW) when no bank is free.
module lvds_rx_frame_writer #(
  parameter int FRAME_WORDS = 256,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       DIN,
  input  logic             DIN_VALID,
  input  logic             DIN_SOF,
  output logic [8:0]       WADDR,
  output logic [31:0]      WD,
  output logic             WEN,
  output logic             BANK_RDY,
  output logic             BANK_ID,
  input  logic             BANK_FREE,
  input  logic             BANK_FREE_ID,
  output logic             OVERFLOW,
  output logic             FRAME_ERR,
  output logic [CNT_W-1:0] FRAME_CNT
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FILL      = 2'd1,
    S_WAIT_BANK = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_WORDS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_full;
  logic             r_cur;
  logic [1:0]       r_lane;
  logic [7:0]       r_idx;
  logic [23:0]      r_bytes;
  logic [8:0]       r_waddr;
  logic [31:0]      r_wd;
  logic             r_wen;
  logic             r_rdy_pend;
  logic             r_pend_bank;
  logic             r_bank_rdy;
  logic             r_bank_id;
  logic             r_overflow;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_start;
  logic             w_accept;
  logic             w_abort;
  logic             w_drop;
  logic             w_word_done;
  logic             w_last;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;
  logic [1:0]       w_full_nxt;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (DIN_VALID && DIN_SOF) begin
          if (!r_full[r_cur]) begin
            w_start     = 1'b1;
            w_state_nxt = S_FILL;
          end else begin
            w_drop      = 1'b1;
            w_state_nxt = S_WAIT_BANK;
          end
        end
      end
      S_FILL: begin
        if (DIN_VALID) begin
          // An SOF anywhere past the first byte aborts and restarts the frame with this byte.
          if (DIN_SOF && (r_lane != 2'd0 || r_idx != 8'd0)) begin
            w_start = 1'b1;
            w_abort = 1'b1;
          end else begin
            w_accept = 1'b1;
            if (r_lane == 2'd3 && r_idx == LAST_IDX) w_state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT_BANK: begin
        w_drop = DIN_VALID;
        if (!r_full[r_cur]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_word_done = w_accept && (r_lane == 2'd3);
  assign w_last      = w_word_done && (r_idx == LAST_IDX);
  assign w_full_set  = w_last ? (2'b01 << r_cur) : 2'b00;
  assign w_full_clr  = BANK_FREE ? (2'b01 << BANK_FREE_ID) : 2'b00;
  // Set is applied after clear so a same-cycle set/clear on one bank keeps it full.
  assign w_full_nxt  = (r_full & ~w_full_clr) | w_full_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_full      <= 2'b00;
      r_cur       <= 1'b0;
      r_lane      <= 2'd0;
      r_idx       <= 8'd0;
      r_bytes     <= 24'd0;
      r_waddr     <= 9'd0;
      r_wd        <= 32'd0;
      r_wen       <= 1'b0;
      r_rdy_pend  <= 1'b0;
      r_pend_bank <= 1'b0;
      r_bank_rdy  <= 1'b0;
      r_bank_id   <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_full      <= w_full_nxt;
      r_wen       <= w_word_done;
      r_frame_err <= w_abort;
      r_rdy_pend  <= w_last;
      r_bank_rdy  <= r_rdy_pend;
      if (w_drop) r_overflow <= 1'b1;

      if (w_word_done) begin
        r_wd    <= {DIN, r_bytes};
        r_waddr <= {r_cur, r_idx};
      end

      if (w_start) begin
        r_bytes[7:0] <= DIN;
        r_lane       <= 2'd1;
        r_idx        <= 8'd0;
      end else if (w_accept) begin
        case (r_lane)
          2'd0:    r_bytes[7:0]   <= DIN;
          2'd1:    r_bytes[15:8]  <= DIN;
          2'd2:    r_bytes[23:16] <= DIN;
          default: r_bytes        <= r_bytes;
        endcase
        r_lane <= w_last ? 2'd0 : r_lane + 2'd1;
        if (w_word_done) r_idx <= w_last ? 8'd0 : r_idx + 8'd1;
      end

      if (w_last) begin
        r_pend_bank <= r_cur;
        r_cur       <= ~r_cur;
      end

      if (r_rdy_pend) begin
        r_bank_id   <= r_pend_bank;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign WADDR     = r_waddr;
  assign WD        = r_wd;
  assign WEN       = r_wen;
  assign BANK_RDY  = r_bank_rdy;
  assign BANK_ID   = r_bank_id;
  assign OVERFLOW  = r_overflow;
  assign FRAME_ERR = r_frame_err;
  assign FRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_lvds_rx_frame_writer.sv
// Directed bench for lvds_rx_frame_writer with 4-word frames; writes and bank handoffs are logged at the falling edge.
module tb_lvds_rx_frame_writer;

  localparam int FW    = 4;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [7:0]       DIN = 8'd0;
  logic             DIN_VALID = 1'b0;
  logic             DIN_SOF = 1'b0;
  logic [8:0]       WADDR;
  logic [31:0]      WD;
  logic             WEN;
  logic             BANK_RDY;
  logic             BANK_ID;
  logic             BANK_FREE = 1'b0;
  logic             BANK_FREE_ID = 1'b0;
  logic             OVERFLOW;
  logic             FRAME_ERR;
  logic [CNT_W-1:0] FRAME_CNT;

  lvds_rx_frame_writer #(.FRAME_WORDS(FW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_SOF(DIN_SOF),
    .WADDR(WADDR), .WD(WD), .WEN(WEN), .BANK_RDY(BANK_RDY), .BANK_ID(BANK_ID),
    .BANK_FREE(BANK_FREE), .BANK_FREE_ID(BANK_FREE_ID), .OVERFLOW(OVERFLOW),
    .FRAME_ERR(FRAME_ERR), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [40:0] wr_q[$];
  int          wr_cyc_q[$];
  logic        rdy_q[$];
  int          rdy_cyc_q[$];
  int          err_cnt = 0;

  always @(negedge CLK) begin
    if (WEN) begin
      wr_q.push_back({WADDR, WD});
      wr_cyc_q.push_back(cyc);
    end
    if (BANK_RDY) begin
      rdy_q.push_back(BANK_ID);
      rdy_cyc_q.push_back(cyc);
    end
    if (FRAME_ERR) err_cnt++;
  end

  int n_chk = 0;
  int n_err = 0;
  int last_cyc = 0;
  int fourth_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_q.delete(); wr_cyc_q.delete(); rdy_q.delete(); rdy_cyc_q.delete();
    err_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b, input logic sof);
    @(negedge CLK);
    DIN = b; DIN_VALID = 1'b1; DIN_SOF = sof;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      DIN_VALID = 1'b0; DIN_SOF = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input int n, input logic sof);
    for (int i = 0; i < n; i++) begin
      send(base + 8'(i), sof && (i == 0));
      if (i == 3) fourth_cyc = cyc;
    end
  endtask

  task automatic free_bank(input logic id);
    @(negedge CLK);
    DIN_VALID = 1'b0; DIN_SOF = 1'b0;
    BANK_FREE = 1'b1; BANK_FREE_ID = id;
    @(negedge CLK);
    BANK_FREE = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    DIN_VALID = 1'b0; DIN_SOF = 1'b0; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Compares FW logged writes starting at log position 'first' against packed bytes b0, b0+1, ...
  task automatic check_frame(input string tag, input logic [8:0] base_addr, input logic [7:0] b0, input int first);
    logic [7:0]  b;
    logic [40:0] exp;
    logic [40:0] got;
    for (int i = 0; i < FW; i++) begin
      b   = b0 + 8'(4 * i);
      exp = {base_addr + 9'(i), b + 8'd3, b + 8'd2, b + 8'd1, b};
      got = (first + i < wr_q.size()) ? wr_q[first + i] : 41'd0;
      check($sformatf("%s.word%0d", tag, i), 64'(got), 64'(exp));
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("reset.outs", 64'({WADDR, WD, WEN, BANK_RDY, BANK_ID, OVERFLOW, FRAME_ERR}), 64'd0);
    check("reset.cnt", 64'(FRAME_CNT), 64'd0);
    RST = 1'b0;
    idle(2);

    // 1: first frame into bank 0
    clear_logs();
    send_frame(8'h00, 16, 1'b1);
    idle(5);
    check("t1.nwr", 64'(wr_q.size()), 64'd4);
    check_frame("t1", 9'h000, 8'h00, 0);
    check("t1.wd0", 64'(wr_q.size() > 0 ? wr_q[0][31:0] : 32'd0), 64'h03020100);
    check("t1.wen_lat", 64'(wr_cyc_q.size() > 0 ? wr_cyc_q[0] - fourth_cyc : -1), 64'd1);
    check("t1.nrdy", 64'(rdy_q.size()), 64'd1);
    check("t1.rdy_id", 64'(rdy_q.size() > 0 ? rdy_q[0] : 1'b1), 64'd0);
    check("t1.rdy_lat", 64'(rdy_cyc_q.size() > 0 ? rdy_cyc_q[0] - last_cyc : -1), 64'd2);
    check("t1.cnt", 64'(FRAME_CNT), 64'd1);

    // 2: second frame into bank 1
    clear_logs();
    send_frame(8'h10, 16, 1'b1);
    idle(5);
    check("t2.nwr", 64'(wr_q.size()), 64'd4);
    check_frame("t2", 9'h100, 8'h10, 0);
    check("t2.rdy_id", 64'(rdy_q.size() > 0 ? rdy_q[0] : 1'b0), 64'd1);
    check("t2.cnt", 64'(FRAME_CNT), 64'd2);
    check("t2.ovf", 64'(OVERFLOW), 64'd0);

    // 3: both banks full -> dropped, then release bank 0
    clear_logs();
    send_frame(8'h20, 16, 1'b1);
    idle(5);
    check("t3.nwr", 64'(wr_q.size()), 64'd0);
    check("t3.nrdy", 64'(rdy_q.size()), 64'd0);
    check("t3.ovf", 64'(OVERFLOW), 64'd1);
    free_bank(1'b0);
    idle(3);
    send_frame(8'h30, 16, 1'b1);
    idle(5);
    check("t3.nwr2", 64'(wr_q.size()), 64'd4);
    check_frame("t3b", 9'h000, 8'h30, 0);
    check("t3.rdy_id", 64'(rdy_q.size() > 0 ? rdy_q[0] : 1'b1), 64'd0);
    check("t3.cnt", 64'(FRAME_CNT), 64'd3);

    // 4: early SOF aborts the frame in bank 1
    free_bank(1'b1);
    free_bank(1'b0);
    idle(2);
    clear_logs();
    send_frame(8'h40, 6, 1'b1);
    send_frame(8'h50, 16, 1'b1);
    idle(5);
    check("t4.ferr", 64'(err_cnt), 64'd1);
    check("t4.nwr", 64'(wr_q.size()), 64'd5);
    check("t4.partial", 64'(wr_q.size() > 0 ? wr_q[0] : 41'd0), 64'({9'h100, 32'h43424140}));
    check_frame("t4", 9'h100, 8'h50, 1);
    check("t4.nrdy", 64'(rdy_q.size()), 64'd1);
    check("t4.rdy_id", 64'(rdy_q.size() > 0 ? rdy_q[0] : 1'b0), 64'd1);
    check("t4.cnt", 64'(FRAME_CNT), 64'd4);

    // 5: reset mid-frame
    free_bank(1'b1);
    idle(2);
    clear_logs();
    send_frame(8'h60, 9, 1'b1);
    @(negedge CLK);
    DIN_VALID = 1'b0; DIN_SOF = 1'b0; RST = 1'b1;
    @(negedge CLK);
    check("t5.outs", 64'({WADDR, WD, WEN, BANK_RDY, BANK_ID, OVERFLOW, FRAME_ERR}), 64'd0);
    check("t5.cnt", 64'(FRAME_CNT), 64'd0);
    RST = 1'b0;
    idle(1);
    clear_logs();
    send_frame(8'h70, 4, 1'b0);
    idle(2);
    check("t5.ignored", 64'(wr_q.size()), 64'd0);
    send_frame(8'h80, 16, 1'b1);
    idle(5);
    check("t5.nwr", 64'(wr_q.size()), 64'd4);
    check_frame("t5", 9'h000, 8'h80, 0);
    check("t5.nrdy", 64'(rdy_q.size()), 64'd1);
    check("t5.cnt", 64'(FRAME_CNT), 64'd1);

    // 6: releasing an empty bank mid-fill changes nothing
    pulse_reset();
    idle(1);
    clear_logs();
    send_frame(8'h90, 8, 1'b1);
    free_bank(1'b1);
    send_frame(8'h98, 8, 1'b0);
    idle(5);
    check("t6.nwr", 64'(wr_q.size()), 64'd4);
    check_frame("t6", 9'h000, 8'h90, 0);
    check("t6.rdy_id", 64'(rdy_q.size() > 0 ? rdy_q[0] : 1'b1), 64'd0);
    check("t6.cnt", 64'(FRAME_CNT), 64'd1);
    check("t6.ovf", 64'(OVERFLOW), 64'd0);
    clear_logs();
    send_frame(8'hA0, 16, 1'b1);
    idle(5);
    check_frame("t6b", 9'h100, 8'hA0, 0);
    check("t6b.rdy_id", 64'(rdy_q.size() > 0 ? rdy_q[0] : 1'b0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
